// File: rtl/dct_macu_sched_if.sv
// dct_macu_sched_if: row-in and coefficient-out valid/ready streams of the DCT MAC scheduler
interface dct_macu_sched_if #(
    parameter int DW = 8,
    parameter int N  = 8,
    parameter int AW = 24
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N*DW-1:0]         din;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [AW-1:0]    dout;
    logic [$clog2(N)-1:0]    dout_idx;
    modport master (output in_valid, din, out_ready, input in_ready, out_valid, dout, dout_idx);
    modport slave  (input in_valid, din, out_ready, output in_ready, out_valid, dout, dout_idx);
endinterface

// File: rtl/dct_macu_sched.sv
// dct_macu_sched: steps one row through the ROM/multiplier/accumulator MAC, one output coefficient at a time
module dct_macu_sched #(
    parameter int DW       = 8,
    parameter int N        = 8,
    parameter int AW       = 24,
    parameter int MULT_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    dct_macu_sched_if.slave             s,
    output logic [2*$clog2(N)-1:0]      coef_addr,
    output logic signed [DW-1:0]        mac_x,
    output logic                        mac_vld,
    output logic                        mac_first,
    input  logic signed [AW-1:0]        acc_in,
    output logic                        busy
);
    localparam int LN = $clog2(N);
    localparam int D  = MULT_LAT + 2;
    localparam int CW = $clog2(D);
    localparam logic [LN-1:0] N_LAST = LN'(N - 1);
    localparam logic [CW-1:0] D_LAST = CW'(D - 1);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;
    state_t               state;
    logic [LN-1:0]        k;
    logic [LN-1:0]        n;
    logic [CW-1:0]        cnt;
    logic signed [DW-1:0] row [N];
    assign coef_addr   = {k, n};
    assign busy        = state != IDLE;
    assign s.in_ready  = ena && state == IDLE;
    assign s.out_valid = state == OUT;
    // the tap pipe advances with the FSM so a frozen ena keeps ROM data and sample aligned
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            n          <= '0;
            cnt        <= '0;
            mac_x      <= '0;
            mac_vld    <= 1'b0;
            mac_first  <= 1'b0;
            s.dout     <= '0;
            s.dout_idx <= '0;
            for (int i = 0; i < N; i++) row[i] <= '0;
        end else if (ena) begin
            mac_vld   <= state == ISSUE;
            mac_first <= state == ISSUE && n == '0;
            mac_x     <= state == ISSUE ? row[n] : '0;
            case (state)
                IDLE:
                    if (s.in_valid) begin
                        for (int i = 0; i < N; i++) row[i] <= s.din[i*DW +: DW];
                        k     <= '0;
                        n     <= '0;
                        state <= ISSUE;
                    end
                ISSUE: begin
                    n <= n + 1'b1;
                    if (n == N_LAST) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    cnt <= cnt == D_LAST ? '0 : cnt + 1'b1;
                    if (cnt == D_LAST) begin
                        s.dout     <= acc_in;
                        s.dout_idx <= k;
                        state      <= OUT;
                    end
                end
                default:
                    if (s.out_ready) begin
                        k     <= k + 1'b1;
                        state <= k == N_LAST ? IDLE : ISSUE;
                    end
            endcase
        end
endmodule

// File: tb/tb_dct_macu_sched.sv
// tb_dct_macu_sched: directed rows through the scheduler with a ROM/MAC model; a scoreboard checks each coefficient
module tb_dct_macu_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ena = 1'b1;
    logic [5:0] coef_addr;
    logic signed [7:0] mac_x;
    logic mac_vld, mac_first, busy;
    logic signed [23:0] acc;
    logic signed [7:0] rom_q;
    logic signed [15:0] mult;
    logic mv, mf;
    int checks = 0;
    int failures = 0;
    int pops = 0;
    typedef struct {int idx; longint val;} exp_t;
    exp_t sb[$];

    localparam logic [63:0] ROW_A = 64'h0101010101010101; // all 1, sum 8
    localparam logic [63:0] ROW_B = 64'h0807060504030201; // 1..8, sum 36
    localparam logic [63:0] ROW_C = 64'hFDFDFDFDFDFDFDFD; // all -3, sum -24
    localparam logic [63:0] ROW_D = 64'h050505050505807F; // 127,-128,5x6, sum 29

    dct_macu_sched_if ifc ();

    dct_macu_sched dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .s(ifc),
        .coef_addr(coef_addr), .mac_x(mac_x), .mac_vld(mac_vld), .mac_first(mac_first),
        .acc_in(acc), .busy(busy)
    );

    always #5 clk = ~clk;

    // macu model: coef(k,n)=k+1, 1-cycle ROM, MULT_LAT=1 product register, load/add accumulator
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rom_q <= '0; mult <= '0; mv <= 1'b0; mf <= 1'b0; acc <= '0;
        end else if (ena) begin
            rom_q <= {5'd0, coef_addr[5:3]} + 8'sd1;
            mult  <= mac_x * rom_q;
            mv    <= mac_vld;
            mf    <= mac_first;
            if (mv) acc <= (mf ? 24'sd0 : acc) + mult;
        end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // monitor: scoreboard pops on handshake, plus tap alignment checks
    initial begin
        logic signed [7:0] lrow [8];
        int run, pn;
        bit le;
        exp_t e;
        run = 0; pn = 0; le = 1'b0;
        foreach (lrow[i]) lrow[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
                le = 1'b0;
            end else begin
                if (le) begin
                    if (mac_vld) begin
                        chk("mac_first", mac_first, run == 0);
                        chk("mac_x", mac_x, lrow[pn]);
                        run++;
                    end else begin
                        chk("mac_first_idle", mac_first, 0);
                        if (run != 0) chk("vld_run", run, 8);
                        run = 0;
                    end
                end
                if (ifc.in_valid && ifc.in_ready)
                    for (int i = 0; i < 8; i++) lrow[i] = ifc.din[i*8 +: 8];
                if (ena && ifc.out_valid && ifc.out_ready) begin
                    pops++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_empty at %0t: got dout %0d expected none", $time, ifc.dout);
                    end else begin
                        e = sb.pop_front();
                        chk("dout", ifc.dout, e.val);
                        chk("dout_idx", ifc.dout_idx, e.idx);
                    end
                end
                if (ena) pn = int'(coef_addr[2:0]);
                le = ena;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_row(input int sum);
        for (int k = 0; k < 8; k++) sb.push_back('{k, longint'((k + 1) * sum)});
    endtask

    task automatic send_row(input logic [63:0] v, input int sum);
        expect_row(sum);
        ifc.din = v;
        ifc.in_valid = 1'b1;
        tick();
        chk("accept_busy", busy, 1);
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int t);
        t = 0;
        while (busy && t < 2000) begin
            tick();
            t++;
        end
        if (t == 2000) chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_valid;
        int t;
        t = 0;
        while (!ifc.out_valid && t < 200) begin
            tick();
            t++;
        end
        if (t == 200) chk("valid_timeout", ifc.out_valid, 1);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_in_ready"}, ifc.in_ready, 1);
        chk({tag, "_coef_addr"}, coef_addr, 0);
        chk({tag, "_mac_x"}, mac_x, 0);
        chk({tag, "_mac_vld"}, mac_vld, 0);
        chk({tag, "_mac_first"}, mac_first, 0);
        chk({tag, "_out_valid"}, ifc.out_valid, 0);
        chk({tag, "_dout"}, ifc.dout, 0);
        chk({tag, "_dout_idx"}, ifc.dout_idx, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int t;
        ifc.in_valid = 1'b0;
        ifc.din = '0;
        ifc.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_vals("reset");
        rst_n = 1'b1;
        tick();
        // row of ones, free-running output: 8,16,..,64 and 96 cycles accept-to-idle
        send_row(ROW_A, 8);
        wait_idle(t);
        chk("row_cycles", t, 96);
        ena = 1'b0;
        #1 chk("in_ready_ena_low", ifc.in_ready, 0);
        ena = 1'b1;
        tick();
        // backpressure at k=3
        ifc.out_ready = 1'b0;
        send_row(ROW_B, 36);
        for (int k = 0; k < 8; k++) begin
            wait_valid();
            if (k == 3)
                repeat (10) begin
                    tick();
                    chk("bp_dout", ifc.dout, 144);
                    chk("bp_dout_idx", ifc.dout_idx, 3);
                    chk("bp_coef_addr", coef_addr, 24);
                    chk("bp_out_valid", ifc.out_valid, 1);
                end
            ifc.out_ready = 1'b1;
            tick();
            ifc.out_ready = 1'b0;
            if (k == 3) begin
                chk("bp_next_addr0", coef_addr, 32);
                chk("bp_next_valid", ifc.out_valid, 0);
                tick();
                chk("bp_next_addr1", coef_addr, 33);
            end
        end
        wait_idle(t);
        ifc.out_ready = 1'b1;
        tick();
        // ena freezes during ISSUE n=4 and DRAIN
        send_row(ROW_C, -24);
        repeat (4) tick();
        ena = 1'b0;
        repeat (5) tick();
        chk("frozen_coef_addr", coef_addr, 4);
        chk("frozen_mac_vld", mac_vld, 1);
        chk("frozen_in_ready", ifc.in_ready, 0);
        ena = 1'b1;
        repeat (5) tick();
        ena = 1'b0;
        repeat (5) tick();
        ena = 1'b1;
        wait_idle(t);
        chk("ena_row_cycles", 19 + t, 106);
        tick();
        // reset in the middle of k=5 ISSUE
        send_row(ROW_A, 8);
        repeat (62) tick();
        chk("pre_reset_addr", coef_addr, 42);
        rst_n = 1'b0;
        #1;
        reset_vals("midreset");
        sb.delete();
        tick();
        chk("reset_held_valid", ifc.out_valid, 0);
        rst_n = 1'b1;
        tick();
        send_row(ROW_D, 29);
        wait_idle(t);
        chk("post_reset_cycles", t, 96);
        tick();
        // back-to-back rows with in_valid held
        expect_row(36);
        expect_row(29);
        ifc.din = ROW_B;
        ifc.in_valid = 1'b1;
        tick();
        ifc.din = ROW_D;
        wait_idle(t);
        chk("b2b_first_cycles", t, 96);
        chk("b2b_in_ready", ifc.in_ready, 1);
        tick();
        chk("b2b_accept", busy, 1);
        ifc.in_valid = 1'b0;
        wait_idle(t);
        chk("b2b_second_cycles", t, 96);
        tick();
        chk("sb_drained", sb.size(), 0);
        chk("pop_count", pops, 53);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
